// File: rtl/wb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter_pkg                                               |
// | Description : Shared defaults and types for the writeback arbiter slice.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// These are the fallbacks used when no project-wide constants header has
// already defined the widths or arbiter defaults.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 4
`endif
`ifndef WB_STARVE_LIMIT
`define WB_STARVE_LIMIT 8
`endif

`default_nettype none

package wb_arbiter_pkg;

    // Which source, if any, owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_PIPE   = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_fifo                                                      |
// | Description : Show-ahead circular buffer for long-latency results.         |
// |               Synchronous write, combinational head, async active-low rst. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    import wb_arbiter_pkg::*;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Storage is data-only; validity is carried entirely by the count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (i_pop && !i_push) r_count <= r_count - 1'b1;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                   |
// | Description : Merges in-order pipeline results and buffered long-latency  |
// |               results onto the single register-file write port, with a     |
// |               starvation stall for the oldest buffered result.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH   = `WORD_WIDTH,
    parameter int ADDR_WIDTH   = `REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = `WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = `WB_STARVE_LIMIT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pipe_valid,
    input  logic [ADDR_WIDTH-1:0]           pipe_rd,
    input  logic [WORD_WIDTH-1:0]           pipe_data,
    input  logic                            ll_valid,
    output logic                            ll_ready,
    input  logic [ADDR_WIDTH-1:0]           ll_rd,
    input  logic [WORD_WIDTH-1:0]           ll_data,
    output logic                            stall_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            rf_w_en,
    output logic [ADDR_WIDTH-1:0]           rf_wa,
    output logic [WORD_WIDTH-1:0]           rf_wd
);

    localparam int                c_ENT_W = ADDR_WIDTH + WORD_WIDTH;
    localparam int                c_AGE_W = $clog2(STARVE_LIMIT+1);
    localparam logic [c_AGE_W-1:0] c_LIMIT = c_AGE_W'(STARVE_LIMIT);

    logic [c_ENT_W-1:0]    w_head;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [WORD_WIDTH-1:0] w_head_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ll_hs;
    logic                  w_ll_live;
    logic                  w_pop;
    logic                  w_push;
    wb_src_e               w_src;
    logic [ADDR_WIDTH-1:0] w_wa;
    logic [WORD_WIDTH-1:0] w_wd;
    logic [c_AGE_W-1:0]    r_age;

    wb_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({ll_rd, ll_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_rd, w_head_data} = w_head;
    assign ll_ready  = !w_full;
    assign stall_req = (r_age == c_LIMIT);
    assign w_ll_hs   = ll_valid && ll_ready;
    // x0 results complete the handshake but are otherwise dropped.
    assign w_ll_live = w_ll_hs && (ll_rd != '0);

    // Priority: starved head, pipeline, buffered head, ll bypass, idle.
    always_comb begin
        w_src = SRC_NONE;
        w_pop = 1'b0;
        w_wa  = w_head_rd;
        w_wd  = w_head_data;
        if (stall_req && !w_empty) begin
            w_src = SRC_FIFO;
            w_pop = 1'b1;
        end else if (pipe_valid && (pipe_rd != '0)) begin
            w_src = SRC_PIPE;
            w_wa  = pipe_rd;
            w_wd  = pipe_data;
        end else if (!w_empty) begin
            w_src = SRC_FIFO;
            w_pop = 1'b1;
        end else if (w_ll_live) begin
            w_src = SRC_BYPASS;
            w_wa  = ll_rd;
            w_wd  = ll_data;
        end
        w_push = w_ll_live && (w_src != SRC_BYPASS);
    end

    // Age of the current FIFO head; saturates so the stall holds until a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_pop || w_empty) begin
            r_age <= '0;
        end else if (r_age != c_LIMIT) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Registered write port; address and data hold when nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w_en <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            rf_w_en <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                rf_wa <= w_wa;
                rf_wd <= w_wd;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                                |
// | Description : Self-checking bench for wb_arbiter with a queue-based model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        stall_req;
    logic [2:0]  fifo_count;
    logic        rf_w_en;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    wb_arbiter #(
        .WORD_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .ll_valid   (ll_valid),
        .ll_ready   (ll_ready),
        .ll_rd      (ll_rd),
        .ll_data    (ll_data),
        .stall_req  (stall_req),
        .fifo_count (fifo_count),
        .rf_w_en    (rf_w_en),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state: queue of waiting results, head age, write port.
    ent_t        mq[$];
    int          m_age;
    logic        m_en;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_hs;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_age = 0;
        m_en  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        m_hs  = 1'b0;
    endtask

    // One clock: check status mid-cycle, advance model, check write port after edge.
    task automatic cycle();
        ent_t e;
        int   n;
        bit   pop;
        bit   issue;
        bit   byp;
        bit   push;
        @(negedge clk);
        chk("ll_ready",   ll_ready,   (mq.size() < DEPTH));
        chk("stall_req",  stall_req,  (m_age == LIMIT));
        chk("fifo_count", fifo_count, mq.size());
        n     = mq.size();
        m_hs  = ll_valid && (n < DEPTH);
        pop   = 0;
        issue = 0;
        byp   = 0;
        if (m_age == LIMIT && n > 0) begin
            pop = 1; issue = 1; m_wa = mq[0].rd; m_wd = mq[0].data;
        end else if (pipe_valid && pipe_rd != 0) begin
            issue = 1; m_wa = pipe_rd; m_wd = pipe_data;
        end else if (n > 0) begin
            pop = 1; issue = 1; m_wa = mq[0].rd; m_wd = mq[0].data;
        end else if (m_hs && ll_rd != 0) begin
            byp = 1; issue = 1; m_wa = ll_rd; m_wd = ll_data;
        end
        push = m_hs && (ll_rd != 0) && !byp;
        m_en = issue;
        if (pop || n == 0) m_age = 0;
        else if (m_age < LIMIT) m_age = m_age + 1;
        if (pop) e = mq.pop_front();
        if (push) begin
            e.rd = ll_rd; e.data = ll_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("rf_w_en", rf_w_en, m_en);
        chk("rf_wa",   rf_wa,   m_wa);
        chk("rf_wd",   rf_wd,   m_wd);
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        ll_valid   = 1'b0; ll_rd   = '0; ll_data   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       idx;
        int       got;
        int       t0;
        int       t_stall;
        bit       full_checked;
        logic [4:0] order[$];

        model_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("reset_w_en",  rf_w_en,    1'b0);
        chk("reset_wa",    rf_wa,      5'd0);
        chk("reset_wd",    rf_wd,      32'd0);
        chk("reset_ready", ll_ready,   1'b1);
        chk("reset_stall", stall_req,  1'b0);
        chk("reset_count", fifo_count, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pipeline-only write and one-cycle pulse.
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        cycle();
        chk("pipe_w_en", rf_w_en, 1'b1);
        chk("pipe_wa",   rf_wa,   5'd5);
        chk("pipe_wd",   rf_wd,   32'hDEADBEEF);
        idle_inputs();
        cycle();
        chk("pipe_pulse_end", rf_w_en, 1'b0);

        // Bypass with an empty FIFO.
        ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h12345678;
        cycle();
        chk("bypass_w_en",  rf_w_en,    1'b1);
        chk("bypass_wa",    rf_wa,      5'd7);
        chk("bypass_wd",    rf_wd,      32'h12345678);
        chk("bypass_count", fifo_count, 3'd0);
        idle_inputs();
        cycle();

        // x0 results from both sources are dropped.
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1111_2222;
        ll_valid   = 1'b1; ll_rd   = 5'd0; ll_data   = 32'h3333_4444;
        cycle();
        chk("x0_w_en",  rf_w_en,    1'b0);
        chk("x0_count", fifo_count, 3'd0);
        chk("x0_ready", ll_ready,   1'b1);
        idle_inputs();
        cycle();

        // Fill under continuous pipeline traffic, starvation stall, drain order.
        idx = 0; got = 0; t0 = -1; t_stall = -1; full_checked = 0;
        for (int k = 0; k < 150 && got < 5; k++) begin
            pipe_valid = !stall_req;
            pipe_rd    = 5'(1 + k % 3);
            pipe_data  = $urandom;
            ll_valid   = (idx < 5);
            ll_rd      = 5'(10 + idx);
            ll_data    = 32'hA000_0000 + 32'(idx);
            cycle();
            if (m_hs && idx < 5) idx++;
            if (t0 < 0 && mq.size() != 0) t0 = cyc;
            if (!full_checked && idx == 4 && mq.size() == DEPTH) begin
                chk("fill_ready_low", ll_ready,   1'b0);
                chk("fill_count",     fifo_count, 3'd4);
                full_checked = 1;
            end
            if (t_stall < 0 && stall_req) t_stall = cyc;
            if (rf_w_en && rf_wa >= 5'd10) begin
                order.push_back(rf_wa);
                got++;
            end
        end
        chk("fill_reached_full", full_checked, 1'b1);
        chk("stall_delay", t_stall - t0, LIMIT);
        chk("drain_count", got, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) chk("drain_order", order[i], 5'(10 + i));
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();

        // Push and pop in the same cycle keep the count and the order.
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0303_0303;
        ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'h2020_2020;
        cycle();
        ll_rd = 5'd21; ll_data = 32'h2121_2121;
        cycle();
        chk("pp_count_before", fifo_count, 3'd2);
        pipe_valid = 1'b0;
        ll_rd = 5'd22; ll_data = 32'h2222_2222;
        cycle();
        chk("pp_head_wa",  rf_wa,      5'd20);
        chk("pp_head_wd",  rf_wd,      32'h2020_2020);
        chk("pp_count",    fifo_count, 3'd2);
        idle_inputs();
        cycle();
        chk("pp_next_wa", rf_wa, 5'd21);
        cycle();
        chk("pp_last_wa", rf_wa, 5'd22);
        cycle();

        // Async reset with three buffered entries and the stall raised.
        for (int k = 0; k < 3; k++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = $urandom;
            ll_valid = 1'b1; ll_rd = 5'(24 + k); ll_data = $urandom;
            cycle();
        end
        ll_valid = 1'b0;
        for (int k = 0; k < 20 && !stall_req; k++) begin
            pipe_valid = 1'b1; pipe_data = $urandom;
            cycle();
        end
        chk("pre_reset_stall", stall_req,  1'b1);
        chk("pre_reset_count", fifo_count, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("async_w_en",  rf_w_en,    1'b0);
        chk("async_count", fifo_count, 3'd0);
        chk("async_ready", ll_ready,   1'b1);
        chk("async_stall", stall_req,  1'b0);
        model_reset();
        idle_inputs();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("no_write_after_reset", rf_w_en, 1'b0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            pipe_valid = ($urandom_range(3) != 0);
            pipe_rd    = 5'($urandom_range(31));
            pipe_data  = $urandom;
            ll_valid   = ($urandom_range(1) != 0);
            ll_rd      = 5'($urandom_range(31));
            ll_data    = $urandom;
            cycle();
        end
        idle_inputs();
        for (int k = 0; k < 8; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
